// File: rtl/fp_mul_normalize_round.sv
// Floating-point multiplier back end: normalizes, rounds and range-checks the raw
// mantissa product, then packs the result. FPM_ROUND_RNE_EN selects round-to-nearest-even; otherwise truncate.
module fp_mul_normalize_round #(
    parameter  int MANT_W   = 24,
    parameter  int EXP_BITS = 8,
    parameter  int EXP_W    = 10,
    localparam int RES_W    = EXP_BITS + MANT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [2*MANT_W-1:0]   in_mant,
    input  logic                  in_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_W-1:0]      out_result,
    output logic                  out_overflow,
    output logic                  out_underflow,
    output logic                  out_inexact
);
    localparam int XW = EXP_W + 1;
    localparam int FW = MANT_W - 1;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((2 ** EXP_BITS) - 1);

    // Stage 1 registers: normalized fraction (hidden bit implied), guard/sticky, widened exponent.
    logic                  s1_valid_q;
    logic                  s1_sign_q, s1_zero_q, s1_illegal_q;
    logic                  s1_guard_q, s1_sticky_q;
    logic signed [XW-1:0]  s1_exp_q;
    logic [FW-1:0]         s1_frac_q;

    logic                  s1_illegal_d, s1_guard_d, s1_sticky_d;
    logic signed [XW-1:0]  s1_exp_d;
    logic [FW-1:0]         s1_frac_d;

    logic                  out_valid_q, ovf_q, unf_q, inx_q;
    logic [RES_W-1:0]      result_q;

    logic                  ovf_d, unf_d, inx_d;
    logic [RES_W-1:0]      result_d;
    logic signed [XW-1:0]  exp_r;
    logic [FW-1:0]         frac_r;

    logic s1_load, s2_adv;

    assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_frac_d    = in_mant[2*MANT_W-2 -: FW];
        s1_guard_d   = in_mant[MANT_W-1];
        s1_sticky_d  = |in_mant[MANT_W-2:0];
        s1_exp_d     = {in_exp[EXP_W-1], in_exp} + EXP_ONE;
        s1_illegal_d = 1'b0;
        if (!in_mant[2*MANT_W-1]) begin
            s1_frac_d    = in_mant[2*MANT_W-3 -: FW];
            s1_guard_d   = in_mant[MANT_W-2];
            s1_sticky_d  = |in_mant[MANT_W-3:0];
            s1_exp_d     = {in_exp[EXP_W-1], in_exp};
            s1_illegal_d = !in_mant[2*MANT_W-2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_illegal_q <= 1'b0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q   <= 1'b1;
                s1_sign_q    <= in_sign;
                s1_zero_q    <= in_zero;
                s1_illegal_q <= s1_illegal_d;
                s1_guard_q   <= s1_guard_d;
                s1_sticky_q  <= s1_sticky_d;
                s1_exp_q     <= s1_exp_d;
                s1_frac_q    <= s1_frac_d;
            end else if (s2_adv) begin
                s1_valid_q   <= 1'b0;
            end
        end
    end

`ifdef FPM_ROUND_RNE_EN
    logic          round_up;
    logic [FW:0]   frac_inc;
    assign round_up = s1_guard_q && (s1_sticky_q || s1_frac_q[0]);
    assign frac_inc = {1'b0, s1_frac_q} + {{FW{1'b0}}, 1'b1};
`endif

    always_comb begin
        frac_r = s1_frac_q;
        exp_r  = s1_exp_q;
`ifdef FPM_ROUND_RNE_EN
        // A carry out of the all-ones fraction renormalizes to 1.0 with the next exponent.
        if (round_up) begin
            if (frac_inc[FW]) begin
                frac_r = '0;
                exp_r  = s1_exp_q + EXP_ONE;
            end else begin
                frac_r = frac_inc[FW-1:0];
            end
        end
`endif
        result_d = {s1_sign_q, exp_r[EXP_BITS-1:0], frac_r};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = s1_guard_q || s1_sticky_q;
        if (s1_zero_q) begin
            result_d = {s1_sign_q, {(RES_W-1){1'b0}}};
            inx_d    = 1'b0;
        end else if (s1_illegal_q) begin
            result_d = {s1_sign_q, {(RES_W-1){1'b0}}};
            unf_d    = 1'b1;
            inx_d    = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
`ifdef FPM_ROUND_RNE_EN
            result_d = {s1_sign_q, {EXP_BITS{1'b1}}, {FW{1'b0}}};
`else
            result_d = {s1_sign_q, {(EXP_BITS-1){1'b1}}, 1'b0, {FW{1'b1}}};
`endif
            ovf_d    = 1'b1;
            inx_d    = 1'b1;
        end else if (exp_r <= EXP_ZERO) begin
            result_d = {s1_sign_q, {(RES_W-1){1'b0}}};
            unf_d    = 1'b1;
            inx_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid_q <= 1'b1;
                result_q    <= result_d;
                ovf_q       <= ovf_d;
                unf_q       <= unf_d;
                inx_q       <= inx_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;
endmodule

// File: tb/tb_fp_mul_normalize_round.sv
// Self-checking bench for fp_mul_normalize_round: directed cases, backpressure,
// async reset, and a randomized run against an arithmetic reference model.
module tb_fp_mul_normalize_round;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic        in_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    logic [34:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [34:0] held = '0;

    fp_mul_normalize_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, want);
        end
    endtask

    // Reference: value-level rounding of mant / 2^shift, independent of guard/sticky bits.
    function automatic logic [34:0] model(input logic s, input int e, input logic [47:0] m, input logic z);
        longint unsigned mant, q, r, half;
        int sh, ex;
        logic inx;
        logic [31:0] res;
        mant = 64'(m);
        if (z) return {s, 31'b0, 3'b000};
        if (mant < (64'd1 << 46)) return {s, 31'b0, 3'b011};
        sh = (mant >= (64'd1 << 47)) ? 24 : 23;
        ex = e + sh - 23;
        q = mant >> sh;
        r = mant - (q << sh);
        half = 64'd1 << (sh - 1);
        inx = (r != 0);
`ifdef FPM_ROUND_RNE_EN
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            ex++;
        end
        if (ex >= 255) return {s, 8'hFF, 23'h0, 3'b101};
`else
        if (ex >= 255) return {s, 8'hFE, 23'h7FFFFF, 3'b101};
`endif
        if (ex <= 0) return {s, 31'b0, 3'b011};
        res = {s, ex[7:0], q[22:0]};
        return {res, 2'b00, inx};
    endfunction

    // Scoreboard: push at accept, pop at delivery, verify hold while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid)
                check("hold_stable", {out_result, out_overflow, out_underflow, out_inexact}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_valid && (exp_q.size() > 0), 1);
                end else begin
                    check("model_result", {out_result, out_overflow, out_underflow, out_inexact},
                          exp_q.pop_front());
                    delivered++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_result, out_overflow, out_underflow, out_inexact};
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sign, int'($signed(in_exp)), in_mant, in_zero));
        end
    end

    task automatic set_beat(input logic s, input int e, input logic [47:0] m, input logic z);
        in_sign = s;
        in_exp  = 10'(e);
        in_mant = m;
        in_zero = z;
    endtask

    task automatic send(input logic s, input int e, input logic [47:0] m, input logic z);
        int n;
        n = 0;
        set_beat(s, e, m, z);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic s, input int e, input logic [47:0] m,
                            input logic z, input logic [34:0] want);
        out_ready = 1'b1;
        send(s, e, m, z);
        check({name, "_lat_early"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({name, "_lat_valid"}, out_valid, 1);
        check(name, {out_result, out_overflow, out_underflow, out_inexact}, want);
    endtask

    initial begin
        int acc, idx, d0, k, e;
        logic acc_now;
        logic [23:0] a, b;
        logic [47:0] m;
        logic [47:0] bp_m[3];
        int bdry[7];
        bp_m[0] = 48'h900000000000;
        bp_m[1] = 48'h400000000000;
        bp_m[2] = 48'h400000C00000;
        bdry = '{-1, 0, 1, 2, 253, 254, 255};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_flags", {out_overflow, out_underflow, out_inexact}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        directed("one_x_one", 0, 127, 48'h400000000000, 0, {32'h3F800000, 3'b000});
        directed("1p5_x_1p5", 0, 127, 48'h900000000000, 0, {32'h40100000, 3'b000});
        directed("tie_even", 0, 127, 48'h400000400000, 0, {32'h3F800000, 3'b001});
`ifdef FPM_ROUND_RNE_EN
        directed("tie_odd", 0, 127, 48'h400000C00000, 0, {32'h3F800002, 3'b001});
        directed("carry_renorm", 0, 127, 48'h7FFFFFFFFFFF, 0, {32'h40000000, 3'b001});
        directed("overflow", 1, 255, 48'h400000000000, 0, {32'hFF800000, 3'b101});
`else
        directed("tie_odd", 0, 127, 48'h400000C00000, 0, {32'h3F800001, 3'b001});
        directed("carry_renorm", 0, 127, 48'h7FFFFFFFFFFF, 0, {32'h3FFFFFFF, 3'b001});
        directed("overflow", 1, 255, 48'h400000000000, 0, {32'hFF7FFFFF, 3'b101});
`endif
        directed("underflow", 0, 0, 48'h400000000000, 0, {32'h00000000, 3'b011});
        directed("zero_path", 1, 200, 48'h000000000123, 1, {32'h80000000, 3'b000});
        directed("illegal_mant", 1, 127, 48'h000000001000, 0, {32'h80000000, 3'b011});

        // Backpressure: three beats offered against a stalled output.
        @(posedge clk);
        #1 out_ready = 1'b0;
        d0 = delivered;
        acc = 0;
        idx = 0;
        set_beat(0, 127, bp_m[0], 0);
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (in_ready) begin
                acc++;
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 3) set_beat(0, 127, bp_m[idx], 0);
            else in_valid = 1'b0;
        end
        check("bp_accepted", acc, 2);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && idx < 3; n++) begin
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_delivered", delivered - d0, 3);
        check("bp_queue_empty", exp_q.size(), 0);

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        send(0, 127, 48'h400000000000, 0);
        send(1, 130, 48'h900000000000, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_result", out_result, 0);
        check("arst_flags", {out_overflow, out_underflow, out_inexact}, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("arst_no_stale", out_valid, 0);
        end

        // Randomized traffic with random output stalls.
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc_now = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc_now) begin
                in_valid = ($urandom_range(0, 3) != 0);
                k = int'($urandom_range(0, 19));
                a = {1'b1, 23'($urandom)};
                b = {1'b1, 23'($urandom)};
                m = a * b;
                e = int'($urandom_range(0, 510)) - 127;
                if (k < 6) e = bdry[$urandom_range(0, 6)];
                if (k == 1) m = {2'b00, 14'($urandom), 32'($urandom)};
                set_beat(1'($urandom), e, m, k == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
